// File: rtl/ctrl_out_mux_gen.sv
// rtl/ctrl_out_mux_gen.sv - shadowed source-select output mux with per-channel pulse generation
module ctrl_out_mux_gen #(
    parameter int NUM_OUT    = 5,
    parameter int NUM_SRC    = 12,
    parameter int SRC_BITS   = 5,
    parameter int PULSE_BITS = 16
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [NUM_OUT*(SRC_BITS+4)-1:0]     ctrl,
    input  logic                                ctrl_update,
    input  logic [PULSE_BITS-1:0]               pulse_len,
    input  logic [NUM_SRC-1:0]                  src,
    output logic [NUM_OUT-1:0]                  out,
    output logic [NUM_OUT-1:0]                  pulse_busy
);

    localparam int CTRL_BITS = SRC_BITS + 4;
    localparam int EXT_BITS  = 2**SRC_BITS;
    localparam logic [SRC_BITS:0] NSRC = (SRC_BITS+1)'(NUM_SRC);

    logic [NUM_SRC-1:0]  src_q;
    logic [NUM_SRC-1:0]  src_d;
    logic [EXT_BITS-1:0] src_q_ext;
    logic [EXT_BITS-1:0] src_d_ext;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_q <= '0;
            src_d <= '0;
        end else begin
            src_q <= src;
            src_d <= src_q;
        end
    end

    // Padding to a full power-of-two lets the select index any value without range issues.
    assign src_q_ext = {{(EXT_BITS-NUM_SRC){1'b0}}, src_q};
    assign src_d_ext = {{(EXT_BITS-NUM_SRC){1'b0}}, src_d};

    for (genvar c = 0; c < NUM_OUT; c++) begin : g_ch
        logic [CTRL_BITS-1:0]  cfg;
        logic [PULSE_BITS-1:0] cnt;
        logic [PULSE_BITS-1:0] cnt_next;
        logic [SRC_BITS-1:0]   sel;
        logic [SRC_BITS-1:0]   idx;
        logic [1:0]            lvl;
        logic [1:0]            mode;
        logic                  fixed;
        logic                  s;
        logic                  p;
        logic                  trig;
        logic                  active;
        logic                  out_next;
        logic                  out_r;

        always_comb begin
            sel   = cfg[SRC_BITS-1:0];
            lvl   = cfg[SRC_BITS+1:SRC_BITS];
            mode  = cfg[SRC_BITS+3:SRC_BITS+2];
            fixed = (sel == '0) || ({1'b0, sel} > NSRC);
            idx   = sel - SRC_BITS'(1);
            s     = src_q_ext[idx];
            p     = src_d_ext[idx];

            case (mode)
                2'b01:   trig = s & ~p;
                2'b10:   trig = ~s & p;
                2'b11:   trig = s ^ p;
                default: trig = 1'b0;
            endcase
            if (fixed) begin
                trig = 1'b0;
            end

            if (trig) begin
                cnt_next = pulse_len;
            end else if (cnt != '0) begin
                cnt_next = cnt - PULSE_BITS'(1);
            end else begin
                cnt_next = '0;
            end
            active = (cnt_next != '0);

            if (lvl[1]) begin
                out_next = 1'b0;
            end else if (mode == 2'b00) begin
                out_next = fixed ? lvl[0] : (lvl[0] ? s : ~s);
            end else begin
                out_next = lvl[0] ? active : ~active;
            end
        end

        // The update edge holds out and clears the counter; new settings drive out one edge later.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cfg   <= '0;
                cnt   <= '0;
                out_r <= 1'b0;
            end else if (ctrl_update) begin
                cfg <= ctrl[(c+1)*CTRL_BITS-1 -: CTRL_BITS];
                cnt <= '0;
            end else begin
                cnt   <= cnt_next;
                out_r <= out_next;
            end
        end

        assign out[c]        = out_r;
        assign pulse_busy[c] = (cnt != '0);
    end

endmodule

// File: tb/tb_ctrl_out_mux_gen.sv
// tb/tb_ctrl_out_mux_gen.sv - directed self-checking bench for ctrl_out_mux_gen
module tb_ctrl_out_mux_gen;

    localparam int NUM_OUT    = 5;
    localparam int NUM_SRC    = 12;
    localparam int SRC_BITS   = 5;
    localparam int PULSE_BITS = 16;
    localparam int CTRL_BITS  = SRC_BITS + 4;

    logic                          clock;
    logic                          reset_n;
    logic [NUM_OUT*CTRL_BITS-1:0]  ctrl;
    logic                          ctrl_update;
    logic [PULSE_BITS-1:0]         pulse_len;
    logic [NUM_SRC-1:0]            src;
    logic [NUM_OUT-1:0]            out;
    logic [NUM_OUT-1:0]            pulse_busy;

    int checks = 0;
    int errors = 0;
    int hi;

    ctrl_out_mux_gen #(
        .NUM_OUT(NUM_OUT), .NUM_SRC(NUM_SRC), .SRC_BITS(SRC_BITS), .PULSE_BITS(PULSE_BITS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .ctrl(ctrl), .ctrl_update(ctrl_update),
        .pulse_len(pulse_len), .src(src), .out(out), .pulse_busy(pulse_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic set_ch(input int c, input logic [1:0] m, input logic [1:0] l, input logic [4:0] s);
        ctrl[c*CTRL_BITS +: CTRL_BITS] = {m, l, s};
    endtask

    task automatic update();
        ctrl_update = 1'b1;
        tick();
        ctrl_update = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ctrl = '0; ctrl_update = 1'b0; pulse_len = '0; src = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        check("rst_out", out, 5'b00000);
        check("rst_busy", pulse_busy, 5'b00000);

        // 1: fixed-high level on ch0
        set_ch(0, 2'b00, 2'b01, 5'd0);
        update();
        check("t1_hold", out, 5'b00000);
        tick();
        check("t1_out", out, 5'b00001);

        // 2: inverted level from src[2] on ch1
        set_ch(1, 2'b00, 2'b00, 5'd3);
        update();
        tick();
        check("t2_idle", out, 5'b00011);
        src[2] = 1'b1;
        tick();
        check("t2_lat", out[1], 1'b1);
        tick();
        check("t2_inv", out, 5'b00001);
        set_ch(1, 2'b00, 2'b01, 5'd3);
        tick(); tick();
        check("t2_noupd", out, 5'b00001);
        set_ch(1, 2'b00, 2'b00, 5'd3);

        // 3: rising pulse on ch2, pulse_len 4
        set_ch(2, 2'b01, 2'b01, 5'd1);
        pulse_len = 16'd4;
        update();
        tick();
        check("t3_idle", out[2], 1'b0);
        src[0] = 1'b1;
        tick();
        check("t3_pre", out[2], 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_pulse", out[2], 1'b1);
            check("t3_busy", pulse_busy[2], 1'b1);
        end
        tick();
        check("t3_end", out[2], 1'b0);
        check("t3_busy_end", pulse_busy[2], 1'b0);
        src[0] = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            hi += int'(out[2]);
        end
        check("t3_fall_nopulse", hi, 0);

        set_ch(2, 2'b01, 2'b00, 5'd1);
        update();
        tick();
        check("t3n_idle", out[2], 1'b1);
        check("t3n_busy", pulse_busy[2], 1'b0);
        src[0] = 1'b1;
        tick();
        check("t3n_pre", out[2], 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3n_pulse", out[2], 1'b0);
        end
        tick();
        check("t3n_end", out[2], 1'b1);

        // 4: both-edge retrigger on ch3, pulse_len 5
        set_ch(3, 2'b11, 2'b01, 5'd1);
        pulse_len = 16'd5;
        update();
        tick();
        check("t4_idle", out[3], 1'b0);
        src[0] = 1'b0;
        hi = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) src[0] = 1'b1;
            tick();
            hi += int'(out[3]);
        end
        check("t4_retrig_len", hi, 8);
        check("t4_end", out[3], 1'b0);
        pulse_len = 16'd0;
        src[0] = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            hi += int'(out[3]) + int'(pulse_busy[3]);
        end
        check("t4_len0", hi, 0);

        // 5: update in the same cycle as a trigger mid-pulse on ch4
        set_ch(4, 2'b01, 2'b01, 5'd1);
        pulse_len = 16'd6;
        update();
        tick();
        src[0] = 1'b1;
        tick(); tick(); tick();
        check("t5_pulse", out[4], 1'b1);
        check("t5_busy", pulse_busy[4], 1'b1);
        src[0] = 1'b0;
        tick();
        src[0] = 1'b1;
        tick();
        update();
        check("t5_hold", out[4], 1'b1);
        check("t5_busy_clr", pulse_busy[4], 1'b0);
        tick();
        check("t5_idle", out[4], 1'b0);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            hi += int'(out[4]);
        end
        check("t5_no_trig", hi, 0);

        // 6: async reset mid-pulse
        src[0] = 1'b0;
        tick(); tick();
        src[0] = 1'b1;
        tick(); tick();
        check("t6_pulse", out[4], 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_out", out, 5'b00000);
        check("t6_async_busy", pulse_busy, 5'b00000);
        tick();
        reset_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            src = ~src;
            tick();
            hi += int'(out != '0) + int'(pulse_busy != '0);
        end
        check("t6_after_rst", hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_out_mux_gen.md
Name: ctrl_out_mux_gen

Overview:
Parametrised successor to the control-output multiplexer. It routes any of NUM_SRC internal status/trigger signals to NUM_OUT physical outputs (out[], bus_en[], LEDs), with per-channel polarity. New per-channel modes generate retriggerable pulses of programmable length on rising, falling or both edges. Configuration is shadowed and applied only on an update strobe, so a register write cannot glitch a live output mid-change. It sits between the AXI control registers and the board output pins.

Parameters:
NUM_OUT, 5, number of output channels.
NUM_SRC, 12, number of input sources; source index k (1..NUM_SRC) selects src[k-1].
SRC_BITS, 5, width of the source-select field; requires 2^SRC_BITS > NUM_SRC.
PULSE_BITS, 16, width of the pulse-length counter.
CTRL_BITS (localparam), SRC_BITS+4, width of one channel configuration word.

Ports:
clock  in  1  system clock; all logic is on this single clock.
reset_n  in  1  asynchronous reset, active low.
ctrl  in  NUM_OUT*CTRL_BITS  channel c word = ctrl[(c+1)*CTRL_BITS-1 -: CTRL_BITS].
ctrl_update  in  1  single-cycle strobe; copies ctrl into the shadow configuration.
pulse_len  in  PULSE_BITS  pulse length in clock cycles, shared by all channels.
src  in  NUM_SRC  source signals; synchronous to clock.
out  out  NUM_OUT  multiplexed outputs, registered.
pulse_busy  out  NUM_OUT  per channel: pulse counter non-zero, uninverted.

Behaviour:
- Reset: out=0, pulse_busy=0, all shadow configuration=0, counters=0, src_q=0, src_d=0.
- Channel word fields:
  - [SRC_BITS-1:0] sel.
  - [SRC_BITS+1:SRC_BITS] lvl: 00 inverted, 01 normal, 1x reserved (forces out=0).
  - [SRC_BITS+3:SRC_BITS+2] mode: 00 level, 01 rising-edge pulse, 10 falling-edge pulse, 11 both-edge pulse.
- Source pipeline: src_q<=src and src_d<=src_q every cycle. Selected s=src_q[sel-1], selected previous p=src_d[sel-1].
- Fixed source: sel=0 or sel>NUM_SRC means fixed. In level mode out=lvl[0] (00 -> low, 01 -> high). In pulse modes the output stays at idle level and never pulses.
- Level mode: out<=s when lvl=01, out<=~s when lvl=00. A src change sampled at edge n appears on out at edge n+1.
- Pulse modes:
  - Trigger: s&~p (rising), ~s&p (falling), or s^p (both).
  - On a trigger the counter loads pulse_len; otherwise it decrements while non-zero.
  - Active = (counter_next != 0). out<=active for lvl=01 and ~active for lvl=00; idle level is therefore 0 or 1 respectively.
  - A trigger sampled at edge n asserts out at edge n+1 and deasserts it at edge n+1+pulse_len, i.e. exactly pulse_len cycles.
  - Retrigger while active reloads the counter, so the pulse extends to pulse_len cycles after the latest trigger.
  - pulse_len=0: a trigger loads 0 and no pulse is produced.
  - A pulse_len change mid-pulse affects only the next load.
- ctrl_update: at the edge where ctrl_update=1, every channel's shadow configuration <= ctrl and every counter <= 0. New configuration takes effect on out at the following edge. If ctrl_update and a trigger occur in the same cycle, the update wins and the trigger is discarded.
- ctrl changes without ctrl_update have no effect on out.
- Asynchronous reset mid-pulse clears everything immediately; outputs resume at the reset values.
- Channels are independent; identical configurations give identical, cycle-aligned outputs.

Test Plan:
1. Reset, no update -> out=00000, pulse_busy=00000. Then ch0 word {mode 00, lvl 01, sel 0} plus update -> out[0]=1 one edge after the update; other channels remain 0.
2. ch1 {mode 00, lvl 00, sel 3}, update; toggle src[2] 0->1 before edge n -> out[1] 1->0 at edge n+1. Change ctrl without update -> out unchanged.
3. ch2 {mode 01, lvl 01, sel 1}, pulse_len=4, one rising edge on src[0] -> out[2]=1 for exactly 4 cycles and pulse_busy[2] identical. A falling edge alone -> no pulse. Same setup with lvl 00 -> idle 1, low pulse for 4 cycles.
4. Retrigger: mode 11, pulse_len=5, src[0] edges 3 cycles apart -> out high for 3+5=8 cycles. pulse_len=0 -> no pulse.
5. ctrl_update asserted in the same cycle as a trigger, with the pulse mid-count -> counter cleared, out returns to idle one edge later, and the trigger is ignored.
6. Assert reset_n=0 during an active pulse -> out and pulse_busy are 0 asynchronously, before the next clock edge. After release the configuration is 0, so outputs stay low.
